// File: rtl/pipeline_stall_ctrl.sv
// Pipeline stall/flush controller: turns a one-cycle hazard code into a timed bubble
// sequence and arbitrates it against branch flush, memory freeze and exception flush.
module pipeline_stall_ctrl #(
  parameter int EXE_BUBBLES = 2,
  parameter int MEM_BUBBLES = 1,
  parameter int CNT_W       = 3,
  parameter int PERF_W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        stall_C,
  input  logic              branch_taken,
  input  logic              mem_busy,
  input  logic              flush_all,
  output logic              pc_en,
  output logic              if_id_en,
  output logic              if_id_flush,
  output logic              id_exe_flush,
  output logic              exe_mem_en,
  output logic              exe_mem_flush,
  output logic              mem_wb_en,
  output logic              hazard_active,
  output logic [PERF_W-1:0] stall_cycles,
  output logic [PERF_W-1:0] freeze_cycles
);

  localparam logic [3:0] NON_STALL = 4'b0000;
  localparam logic [3:0] MEM_STALL = 4'b0010;

  localparam logic [CNT_W-1:0] EXE_CNT = CNT_W'(EXE_BUBBLES - 1);
  localparam logic [CNT_W-1:0] MEM_CNT = CNT_W'(MEM_BUBBLES - 1);

  typedef enum logic {RUN, HAZARD} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [PERF_W-1:0] stall_q, stall_d;
  logic [PERF_W-1:0] freeze_q, freeze_d;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    stall_d       = stall_q;
    freeze_d      = freeze_q;
    pc_en         = 1'b1;
    if_id_en      = 1'b1;
    if_id_flush   = 1'b0;
    id_exe_flush  = 1'b0;
    exe_mem_en    = 1'b1;
    exe_mem_flush = 1'b0;
    mem_wb_en     = 1'b1;

    if (rst) begin
      pc_en         = 1'b0;
      if_id_en      = 1'b0;
      exe_mem_en    = 1'b0;
      mem_wb_en     = 1'b0;
      if_id_flush   = 1'b1;
      id_exe_flush  = 1'b1;
      exe_mem_flush = 1'b1;
    end else if (flush_all) begin
      if_id_flush   = 1'b1;
      id_exe_flush  = 1'b1;
      exe_mem_flush = 1'b1;
      state_d       = RUN;
      cnt_d         = '0;
    end else if (mem_busy) begin
      // Freeze: nothing advances, so the hazard countdown holds too.
      pc_en      = 1'b0;
      if_id_en   = 1'b0;
      exe_mem_en = 1'b0;
      mem_wb_en  = 1'b0;
      freeze_d   = freeze_q + PERF_W'(1);
    end else if (state_q == HAZARD || stall_C != NON_STALL) begin
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_exe_flush = 1'b1;
      stall_d      = stall_q + PERF_W'(1);
      if (state_q == HAZARD) begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = RUN;
      end else begin
        // Unknown codes are handled as the longer EXE-producer case.
        cnt_d   = (stall_C == MEM_STALL) ? MEM_CNT : EXE_CNT;
        state_d = (cnt_d != '0) ? HAZARD : RUN;
      end
    end else if (branch_taken) begin
      if_id_flush = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= RUN;
      cnt_q    <= '0;
      stall_q  <= '0;
      freeze_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      stall_q  <= stall_d;
      freeze_q <= freeze_d;
    end
  end

  assign hazard_active = (state_q == HAZARD);
  assign stall_cycles  = stall_q;
  assign freeze_cycles = freeze_q;

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Randomized scoreboard bench for pipeline_stall_ctrl against a pending-bubble-count model.
module tb_pipeline_stall_ctrl;
  localparam int EXE_B = 2;
  localparam int MEM_B = 1;
  localparam int PW    = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic [3:0]    stall_C;
  logic          branch_taken, mem_busy, flush_all;
  logic          pc_en, if_id_en, if_id_flush, id_exe_flush;
  logic          exe_mem_en, exe_mem_flush, mem_wb_en, hazard_active;
  logic [PW-1:0] stall_cycles, freeze_cycles;

  pipeline_stall_ctrl #(.EXE_BUBBLES(EXE_B), .MEM_BUBBLES(MEM_B), .CNT_W(3), .PERF_W(PW)) dut (
    .clk(clk), .rst(rst), .stall_C(stall_C), .branch_taken(branch_taken),
    .mem_busy(mem_busy), .flush_all(flush_all), .pc_en(pc_en), .if_id_en(if_id_en),
    .if_id_flush(if_id_flush), .id_exe_flush(id_exe_flush), .exe_mem_en(exe_mem_en),
    .exe_mem_flush(exe_mem_flush), .mem_wb_en(mem_wb_en), .hazard_active(hazard_active),
    .stall_cycles(stall_cycles), .freeze_cycles(freeze_cycles)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] ctl;   // {pc_en,if_id_en,if_id_flush,id_exe_flush,exe_mem_en,exe_mem_flush,mem_wb_en,hazard_active}
    int unsigned stalls;
    int unsigned freezes;
    int          tag;
  } exp_t;

  exp_t sb_q[$];
  int checks = 0;
  int errors = 0;
  int txn = 0;

  // Model: bubbles still owed after the current one, plus perf totals.
  int          pending = 0;
  int unsigned m_stalls = 0;
  int unsigned m_freezes = 0;

  task automatic push_exp(input logic r, input logic [3:0] code, input logic br,
                          input logic busy, input logic fl);
    exp_t e;
    logic hz;
    hz = (pending > 0);
    if (r) begin
      pending = 0; m_stalls = 0; m_freezes = 0;
      e.ctl = 8'b0011_0100;
    end else if (fl) begin
      e.ctl = {1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, hz};
    end else if (busy) begin
      e.ctl = {7'b0000000, hz};
    end else if (hz || code != 4'd0) begin
      e.ctl = {1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, hz};
    end else if (br) begin
      e.ctl = {1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    end else begin
      e.ctl = 8'b1100_1010;
    end
    e.stalls = m_stalls;
    e.freezes = m_freezes;
    e.tag = txn;
    sb_q.push_back(e);
    // Advance the model for the next cycle.
    if (!r) begin
      if (fl) pending = 0;
      else if (busy) m_freezes++;
      else if (hz) begin pending--; m_stalls++; end
      else if (code != 4'd0) begin
        pending = ((code == 4'd2) ? MEM_B : EXE_B) - 1;
        m_stalls++;
      end
    end
  endtask

  task automatic cyc(input logic [3:0] code, input logic br, input logic busy,
                     input logic fl, input logic r = 1'b0);
    @(posedge clk);
    #1;
    rst = r; stall_C = code; branch_taken = br; mem_busy = busy; flush_all = fl;
    txn++;
    push_exp(r, code, br, busy, fl);
  endtask

  // Monitor: every scoreboard entry corresponds to one cycle's output.
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      exp_t e;
      logic [7:0] act;
      e = sb_q.pop_front();
      act = {pc_en, if_id_en, if_id_flush, id_exe_flush, exe_mem_en, exe_mem_flush,
             mem_wb_en, hazard_active};
      checks++;
      if (act !== e.ctl) begin
        errors++;
        $display("FAIL ctl txn %0d: got %b expected %b", e.tag, act, e.ctl);
      end
      checks++;
      if (stall_cycles !== PW'(e.stalls)) begin
        errors++;
        $display("FAIL stall_cycles txn %0d: got %0d expected %0d", e.tag, stall_cycles, e.stalls);
      end
      checks++;
      if (freeze_cycles !== PW'(e.freezes)) begin
        errors++;
        $display("FAIL freeze_cycles txn %0d: got %0d expected %0d", e.tag, freeze_cycles, e.freezes);
      end
      $display("txn %0d ctl=%b stalls=%0d freezes=%0d", e.tag, act, stall_cycles, freeze_cycles);
    end
  end

  initial begin
    logic [3:0] code;
    int r;
    rst = 1'b1; stall_C = 4'd0; branch_taken = 1'b0; mem_busy = 1'b0; flush_all = 1'b0;
    cyc(4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc(4'd0, 1'b0, 1'b0, 1'b0);
    // Two-bubble EXE hazard, then single-bubble MEM hazard.
    cyc(4'd1, 1'b0, 1'b0, 1'b0);
    cyc(4'd0, 1'b0, 1'b0, 1'b0);
    cyc(4'd0, 1'b0, 1'b0, 1'b0);
    cyc(4'd2, 1'b0, 1'b0, 1'b0);
    cyc(4'd0, 1'b0, 1'b0, 1'b0);
    // EXE hazard frozen three cycles mid-sequence.
    cyc(4'd1, 1'b0, 1'b0, 1'b0);
    repeat (3) cyc(4'd1, 1'b1, 1'b1, 1'b0);
    cyc(4'd0, 1'b0, 1'b0, 1'b0);
    cyc(4'd0, 1'b0, 1'b0, 1'b0);
    // Exception flush aborts a hazard with one bubble left.
    cyc(4'd1, 1'b0, 1'b0, 1'b0);
    cyc(4'd0, 1'b0, 1'b0, 1'b1);
    cyc(4'd0, 1'b0, 1'b0, 1'b0);
    // Branch alongside a stall versus branch alone; unrecognised code.
    cyc(4'd1, 1'b1, 1'b0, 1'b0);
    cyc(4'd0, 1'b1, 1'b0, 1'b0);
    cyc(4'd0, 1'b1, 1'b0, 1'b0);
    cyc(4'hA, 1'b0, 1'b0, 1'b0);
    cyc(4'd2, 1'b0, 1'b0, 1'b0);
    // Reset in the middle of a hazard.
    cyc(4'd1, 1'b0, 1'b0, 1'b0);
    cyc(4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc(4'd0, 1'b0, 1'b0, 1'b0);
    // Randomized traffic.
    for (int i = 0; i < 500; i++) begin
      r = $urandom_range(0, 99);
      code = (r < 60) ? 4'd0 : (r < 78) ? 4'd1 : (r < 94) ? 4'd2 : 4'($urandom_range(3, 15));
      cyc(code, ($urandom_range(0, 99) < 30), ($urandom_range(0, 99) < 15),
          ($urandom_range(0, 99) < 4), ($urandom_range(0, 199) == 0));
    end
    cyc(4'd0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 10 && sb_q.size() > 0; k++) @(posedge clk);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left expected 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
